// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller wrapped around a 16x8 single-port RAM with registered read.
// One RAM operation per cycle; reads and writes alternate when both are possible.
module ram_fifo_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       mem_we,
  output logic       mem_re,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StRdWait = 1'b1;

  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] wptr_q, wptr_d;
  logic [3:0] rptr_q, rptr_d;
  logic [4:0] count_q, count_d;
  logic       last_op_q, last_op_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic wr_ok, rd_ok, wr_xfer, rd_start;

  assign wr_ok = (state_q == StIdle) && (count_q < 5'd16);
  assign rd_ok = (state_q == StIdle) && (count_q != 5'd0) && !out_valid_q;

  // A pending read blocks the producer only if the previous op was a write.
  assign in_ready = !reset && wr_ok && !(rd_ok && (last_op_q == OpWrite));
  assign wr_xfer  = in_valid && in_ready;
  assign rd_start = !reset && rd_ok && !wr_xfer;

  assign mem_we   = wr_xfer;
  assign mem_re   = rd_start;
  assign mem_addr = wr_xfer ? wptr_q : rptr_q;
  assign mem_din  = wr_xfer ? in_data : 8'h00;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign full      = (count_q == 5'd16);
  assign empty     = (count_q == 5'd0);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    last_op_d   = last_op_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == StRdWait) begin
      out_data_d  = mem_dout;
      out_valid_d = 1'b1;
      state_d     = StIdle;
    end else if (wr_xfer) begin
      wptr_d    = wptr_q + 4'd1;
      count_d   = count_q + 5'd1;
      last_op_d = OpWrite;
    end else if (rd_start) begin
      rptr_d    = rptr_q + 4'd1;
      count_d   = count_q - 5'd1;
      last_op_d = OpRead;
      state_d   = StRdWait;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wptr_q      <= 4'd0;
      rptr_q      <= 4'd0;
      count_q     <= 5'd0;
      last_op_q   <= OpRead;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      last_op_q   <= last_op_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, scoreboard of accepted bytes checked at the output.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  int         n_out;
  logic       both_seen, we_full_seen, re_seen, ov_seen;
  logic [4:0] max_count;

  logic [7:0] ram [16];

  ram_fifo_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and sticky observation flags, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        else check("out_order", 32'(out_data), 32'(sb.pop_front()));
      end
      if (mem_we && mem_re) both_seen = 1'b1;
      if (full && mem_we) we_full_seen = 1'b1;
      if (mem_re) re_seen = 1'b1;
      if (out_valid) ov_seen = 1'b1;
      if (count > max_count) max_count = count;
    end
  end

  task automatic clear_flags();
    both_seen = 1'b0; we_full_seen = 1'b0; re_seen = 1'b0; ov_seen = 1'b0;
    max_count = 5'd0; n_out = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    clear_flags();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && count == 5'd0 && !out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    clear_flags();

    // Reset cycle: handshake and RAM strobes held low even with in_valid high.
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    do_reset();

    // Three bytes, consumer stalled: first byte parked on out_data, two left in RAM.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    idle(4);
    check("w3_count", 32'(count), 32'd2);
    check("w3_out_valid", 32'(out_valid), 32'd1);
    check("w3_out_data", 32'(out_data), 32'h11);
    check("w3_no_both", 32'(both_seen), 32'd0);

    // Fill: 16 accepted leaves 15 in RAM; one more reaches full.
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    idle(3);
    check("fill_count15", 32'(count), 32'd15);
    check("fill_out_data", 32'(out_data), 32'hA0);
    push_byte(8'hB0);
    @(negedge clk);
    check("fill_count16", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hEE;
    idle(5);
    check("fill_no_we_full", 32'(we_full_seen), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("fill_drained", 32'(n_out), 32'd17);
    check("fill_empty", 32'(empty), 32'd1);
    check("fill_no_both", 32'(both_seen), 32'd0);

    // Stream 40 bytes with both sides ready: ordering across two pointer wraps.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) push_byte(8'(i));
    wait_drain();
    check("stream_n_out", 32'(n_out), 32'd40);
    check("stream_alternate", 32'(max_count), 32'd1);
    check("stream_no_both", 32'(both_seen), 32'd0);

    // Reset while waiting on a read with five bytes still in RAM.
    do_reset();
    for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
    idle(2);
    check("rdw_pre_count", 32'(count), 32'd6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rdw_read_start", 32'(mem_re), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rdw_wait_count", 32'(count), 32'd5);
    check("rdw_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rdw_count", 32'(count), 32'd0);
    check("rdw_empty", 32'(empty), 32'd1);
    check("rdw_out_valid", 32'(out_valid), 32'd0);
    check("rdw_out_data", 32'(out_data), 32'h00);

    // Empty and idle producer: no spurious read or output.
    do_reset();
    out_ready = 1'b1;
    idle(10);
    check("empty_no_re", 32'(re_seen), 32'd0);
    check("empty_no_ov", 32'(ov_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
